// File: rtl/pipeline_control_fsm.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritizes memory freeze,
// mispredict flush, load-use stall and ecall halt drain, and keeps saturating perf counters.
module pipeline_control_fsm #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_is_stall,
  input  logic             i_mispredict,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  input  logic             i_halt_req,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_write,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_write,
  output logic             o_mem_wb_bubble,
  output logic             o_halted,
  output logic [1:0]       o_ctrl_state,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  localparam logic [1:0]       DRAIN_INIT = 2'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           r_state;
  logic [1:0]       r_drain_cnt;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  state_t     w_next_state;
  logic [1:0] w_next_drain;
  logic       w_mem_busy;
  logic       w_stall_inc;
  logic       w_flush_inc;

  assign w_mem_busy = i_dmem_req & ~i_dmem_ready;

  // Mealy control decode: priority freeze > flush > stall > halt in RUN/MEM_WAIT.
  always_comb begin
    o_pc_write      = 1'b1;
    o_if_id_write   = 1'b1;
    o_if_id_flush   = 1'b0;
    o_id_ex_write   = 1'b1;
    o_id_ex_flush   = 1'b0;
    o_ex_mem_write  = 1'b1;
    o_mem_wb_bubble = 1'b0;
    o_halted        = 1'b0;
    w_next_state    = r_state;
    w_next_drain    = r_drain_cnt;
    w_stall_inc     = 1'b0;
    w_flush_inc     = 1'b0;
    if (!i_reset) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_write  = 1'b0;
      o_ex_mem_write = 1'b0;
      w_next_state   = ST_RUN;
      w_next_drain   = 2'd0;
    end else begin
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          if (w_mem_busy) begin
            o_pc_write      = 1'b0;
            o_if_id_write   = 1'b0;
            o_id_ex_write   = 1'b0;
            o_ex_mem_write  = 1'b0;
            o_mem_wb_bubble = 1'b1;
            w_next_state    = ST_MEM_WAIT;
            w_stall_inc     = 1'b1;
          end else if (i_mispredict) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            w_next_state  = ST_RUN;
            w_flush_inc   = 1'b1;
          end else if (i_is_stall) begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_id_ex_flush = 1'b1;
            w_next_state  = ST_RUN;
            w_stall_inc   = 1'b1;
          end else if (i_halt_req) begin
            o_pc_write    = 1'b0;
            o_if_id_flush = 1'b1;
            w_next_state  = ST_DRAIN;
            w_next_drain  = DRAIN_INIT;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_DRAIN: begin
          // Fetch stays squashed; only the ecall and older work move downstream.
          o_pc_write    = 1'b0;
          o_if_id_flush = 1'b1;
          if (w_mem_busy) begin
            o_id_ex_write   = 1'b0;
            o_ex_mem_write  = 1'b0;
            o_mem_wb_bubble = 1'b1;
          end else if (r_drain_cnt == 2'd0) begin
            w_next_state = ST_HALT;
          end else begin
            w_next_drain = r_drain_cnt - 2'd1;
          end
        end
        ST_HALT: begin
          o_pc_write      = 1'b0;
          o_if_id_write   = 1'b0;
          o_id_ex_write   = 1'b0;
          o_ex_mem_write  = 1'b0;
          o_mem_wb_bubble = 1'b1;
          o_halted        = 1'b1;
        end
        default: begin
          o_pc_write      = 1'b0;
          o_if_id_write   = 1'b0;
          o_id_ex_write   = 1'b0;
          o_ex_mem_write  = 1'b0;
          o_mem_wb_bubble = 1'b1;
          w_next_state    = ST_RUN;
          w_next_drain    = 2'd0;
        end
      endcase
    end
  end

  // State, drain counter and saturating performance counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= ST_RUN;
      r_drain_cnt   <= 2'd0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain;
      if (w_stall_inc && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_flush_inc && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_ctrl_state  = r_state;
  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;

endmodule

// File: doc/pipeline_control_fsm.md
# pipeline_control_fsm

Central stall/flush sequencer for the 5-stage pipeline. Combines the load-use/ecall stall request, EX-stage branch mispredict, variable-latency data-memory wait, and ecall-halt drain into one prioritized set of per-stage write enables and flushes. Keeps saturating stall/flush performance counters. Sits beside the hazard detection unit and drives the PC and all four pipeline registers.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles from halt acceptance in ID until the ecall retires in WB
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on the rising edge of clk)
- is_stall  in  1  load-use / ecall-operand stall request from hazard detection
- mispredict  in  1  EX-stage branch/jump resolved against the fetched path
- dmem_req  in  1  instruction in MEM is accessing data memory this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- halt_req  in  1  ID holds a halting ecall (x17 == 10)
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID loads a bubble
- id_ex_write  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX loads a bubble
- ex_mem_write  out  1  EX/MEM enable
- mem_wb_bubble  out  1  MEM/WB loads a bubble
- halted  out  1  pipeline drained and stopped
- ctrl_state  out  2  RUN=0, MEM_WAIT=1, DRAIN=2, HALT=3
- stall_count  out  CNT_W  saturating stall-cycle counter
- flush_count  out  CNT_W  saturating mispredict counter

## Operation
- Registered state: ctrl_state, drain_cnt (2 bits, sized for DRAIN_CYCLES), stall_count, flush_count. All control outputs are combinational from the state and the current inputs (Mealy), so they take effect in the same cycle.
- Defaults: all *_write = 1, all flushes/bubble = 0, halted = 0.
- mem_busy = dmem_req & ~dmem_ready. Priority is evaluated in RUN and MEM_WAIT, highest first:
  1. mem_busy: pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_bubble = 1; no flushes. Next state MEM_WAIT.
  2. mispredict: if_id_flush = 1, id_ex_flush = 1; PC loads the target. flush_count++.
  3. is_stall: pc_write = 0, if_id_write = 0, id_ex_flush = 1.
  4. halt_req: pc_write = 0, if_id_flush = 1. Next state DRAIN, drain_cnt = DRAIN_CYCLES - 1.
  - Any case other than 1 returns the FSM to RUN.
- In MEM_WAIT, the same priority applies. When dmem_ready = 1 the freeze lifts in that same cycle.
- DRAIN:
  - pc_write = 0 and if_id_flush = 1 always. Downstream stages advance.
  - mem_busy freezes ID/EX, EX/MEM and MEM/WB as in rule 1, and drain_cnt holds.
  - Otherwise drain_cnt decrements. On a non-busy cycle with drain_cnt == 0, next state is HALT.
  - mispredict, is_stall and halt_req are ignored.
- HALT: all *_write = 0, mem_wb_bubble = 1, halted = 1. The FSM stays here until reset.
- stall_count increments on every cycle in RUN or MEM_WAIT where pc_write = 0 because of rule 1 or rule 3. Both counters saturate at 2^CNT_W - 1 and never wrap.

## Timing
- Reset (reset = 0 at an edge): ctrl_state = RUN, drain_cnt = 0, both counters = 0.
- While reset is low, combinational outputs are forced: all *_write = 0, all flushes/bubble = 0, halted = 0.
- Reset asserted mid-DRAIN or in HALT returns the FSM to RUN on the next edge.
- Output latency is 0 cycles from inputs. State and counter latency is 1 cycle.
- halt_req to halted: DRAIN_CYCLES + 1 cycles with no memory waits. Each busy memory cycle during DRAIN adds 1.
- Simultaneous events:
  - mispredict + is_stall: the flush wins; the stall is not counted.
  - mispredict + halt_req: the ecall is squashed and the FSM stays in RUN.
  - is_stall + halt_req: stall only; halt is re-evaluated next cycle.
  - mem_busy + anything: the freeze wins; the mispredict is not counted until the cycle it takes effect.

## Test plan
- Load-use: is_stall = 1 for 1 cycle -> pc_write = 0, if_id_write = 0, id_ex_flush = 1, stall_count 0 -> 1, state stays RUN.
- Memory wait: dmem_req = 1 with dmem_ready low for 3 cycles then high -> 3 frozen cycles, ctrl_state = MEM_WAIT for 3 cycles, stall_count = 3, all enables return to 1 on the ready cycle.
- Mispredict during mem wait: mispredict = 1 held through a 2-cycle wait -> no flush during the wait; flush asserted on the ready cycle; flush_count = 1.
- Halt drain: halt_req pulse with DRAIN_CYCLES = 3 -> DRAIN for 3 cycles, halted = 1 on cycle 4; add 2 busy memory cycles in DRAIN -> halted on cycle 6.
- Priority: mispredict + halt_req together -> flushes, state RUN, halted never set. is_stall + halt_req -> stall only.
- Saturation/reset: preload near max by forcing ~2^CNT_W stalls (or use CNT_W = 4) -> stall_count holds at 15. Then reset = 0 in HALT -> RUN, counters 0, halted = 0.
